// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage constants, types and the fetch-fault helper
//
// Purpose: single home for the word size, instruction-memory size, the default
// reset and exception PCs, the next-PC source encoding and the fault check
// used by the fetch stage. No ports.
`ifndef FETCH_STAGE_DEFS
`define FETCH_STAGE_DEFS
`define WORD_SIZE 32
`define INSTR_MEM_SIZE 1024
`endif

package fetch_stage_pkg;

  localparam int unsigned WORD_W     = `WORD_SIZE;
  localparam int unsigned IMEM_WORDS = `INSTR_MEM_SIZE;

  typedef logic [`WORD_SIZE-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam word_t EXC_VECTOR_DEFAULT = 32'h0000_0100;

  // Next-PC source selected by pc_reg once reset is out of the way.
  typedef enum logic [1:0] {
    PC_EXC      = 2'd0,
    PC_REDIRECT = 2'd1,
    PC_HOLD     = 2'd2,
    PC_SEQ      = 2'd3
  } pc_sel_e;

  // A fetch faults when the address is not word aligned or the word index
  // falls past the end of instruction memory.
  function automatic logic fetch_fault(input word_t pc);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[`WORD_SIZE-1:2]} >= word_t'(IMEM_WORDS));
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter register with its next-PC priority mux
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   stall                - hold the PC when nothing higher-priority happens
//   redirect_valid/_pc   - taken branch/jump and its target
//   exc_valid            - exception entry, loads EXC_VECTOR
//   pc                   - current PC register value
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [`WORD_SIZE-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [`WORD_SIZE-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [`WORD_SIZE-1:0]   redirect_pc,
  input  logic                    exc_valid,
  output logic [`WORD_SIZE-1:0]   pc
);

  pc_sel_e sel;

  // Exception and redirect both override stall; stall only freezes
  // sequential advance.
  always_comb begin
    sel = PC_SEQ;
    if (exc_valid)           sel = PC_EXC;
    else if (redirect_valid) sel = PC_REDIRECT;
    else if (stall)          sel = PC_HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_EXC:      pc <= EXC_VECTOR;
        PC_REDIRECT: pc <= redirect_pc;   // misaligned targets load unmodified
        PC_HOLD:     pc <= pc;
        PC_SEQ:      pc <= pc + 32'd4;    // wraps modulo 2^32
        default:     pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register plus IF/ID pipeline register
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   stall, flush              - hold PC and IF/ID / invalidate IF/ID
//   redirect_valid/_pc        - taken branch/jump and its target
//   exc_valid                 - exception entry request
//   imem_pc, imem_instr       - instruction memory address and combinational read data
//   ifid_valid/_instr/_pc/_pc_plus4/_fault - IF/ID register contents
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [`WORD_SIZE-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [`WORD_SIZE-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    redirect_valid,
  input  logic [`WORD_SIZE-1:0]   redirect_pc,
  input  logic                    exc_valid,
  output logic [`WORD_SIZE-1:0]   imem_pc,
  input  logic [`WORD_SIZE-1:0]   imem_instr,
  output logic                    ifid_valid,
  output logic [`WORD_SIZE-1:0]   ifid_instr,
  output logic [`WORD_SIZE-1:0]   ifid_pc,
  output logic [`WORD_SIZE-1:0]   ifid_pc_plus4,
  output logic                    ifid_fault
);

  logic [`WORD_SIZE-1:0] pc;
  logic                  fault;
  logic                  discard;

  pc_reg #(
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .pc             (pc)
  );

  // The memory is addressed straight from the PC register, so the word
  // presented on imem_instr this cycle belongs to pc.
  assign imem_pc = pc;
  assign fault   = fetch_fault(pc);

  // Anything that changes the control flow makes the current fetch wrong-path.
  assign discard = flush | exc_valid | redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      ifid_fault    <= 1'b0;
    end else if (discard) begin
      // Payload fields are don't-care while invalid, so only valid drops.
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_valid    <= 1'b1;
      ifid_instr    <= fault ? '0 : imem_instr;
      ifid_pc       <= pc;
      ifid_pc_plus4 <= pc + 32'd4;
      ifid_fault    <= fault;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        exc_valid = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_fault;

  int vectors = 0;
  int errs = 0;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC_PC  = 32'h0000_0100;
  localparam int          MEM_WDS = 1024;

  // Reference state: architectural PC and the IF/ID entry.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr, m_ipc, m_ip4;
  logic        m_fault;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_fault     (ifid_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  assign imem_instr = mem_word(imem_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the reference from the inputs seen at the
  // edge, then compare once outputs have settled.
  task automatic tick();
    logic f;
    @(posedge clk);
    if (rst) begin
      m_pc = RST_PC; m_valid = 0; m_instr = 0; m_ipc = 0; m_ip4 = 0; m_fault = 0;
    end else begin
      f = (m_pc % 4 != 0) || ((m_pc / 4) >= MEM_WDS);
      if (flush || exc_valid || redirect_valid) m_valid = 0;
      else if (!stall) begin
        m_valid = 1; m_instr = f ? 32'h0 : mem_word(m_pc);
        m_ipc = m_pc; m_ip4 = m_pc + 4; m_fault = f;
      end
      if (exc_valid) m_pc = EXC_PC;
      else if (redirect_valid) m_pc = redirect_pc;
      else if (!stall) m_pc = m_pc + 4;
    end
    #1;
    chk("model_imem_pc", imem_pc, m_pc);
    chk("model_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("model_instr", ifid_instr, m_instr);
      chk("model_ifid_pc", ifid_pc, m_ipc);
      chk("model_pc4", ifid_pc_plus4, m_ip4);
      chk("model_fault", {31'b0, ifid_fault}, {31'b0, m_fault});
    end
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid = 1; redirect_pc = t;
    tick();
    redirect_valid = 0;
    tick();
  endtask

  initial begin
    // reset for two cycles
    tick(); tick();
    chk("rst_pc", imem_pc, RST_PC);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_pc4", ifid_pc_plus4, 32'h0);
    chk("rst_fault", {31'b0, ifid_fault}, 32'h0);

    rst = 0;
    tick();
    chk("run0_pc", ifid_pc, 32'h0);
    chk("run0_valid", {31'b0, ifid_valid}, 32'h1);
    tick();
    chk("run1_pc", ifid_pc, 32'h4);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_imem", imem_pc, 32'h8);
      chk("stall_ifid", ifid_pc, 32'h4);
      chk("stall_valid", {31'b0, ifid_valid}, 32'h1);
    end
    stall = 0;
    tick();
    chk("unstall_ifid", ifid_pc, 32'h8);
    chk("unstall_imem", imem_pc, 32'hC);

    redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    chk("redir_imem", imem_pc, 32'h40);
    chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
    redirect_valid = 0;
    tick();
    chk("redir_ifid", ifid_pc, 32'h40);

    // flush dominates stall
    flush = 1; stall = 1;
    tick();
    chk("flush_valid", {31'b0, ifid_valid}, 32'h0);
    chk("flush_hold_pc", imem_pc, 32'h44);
    flush = 0; stall = 0;
    tick();
    chk("post_flush_ifid", ifid_pc, 32'h44);

    exc_valid = 1; redirect_valid = 1; redirect_pc = 32'h80; stall = 1;
    tick();
    chk("exc_pc", imem_pc, 32'h100);
    chk("exc_valid", {31'b0, ifid_valid}, 32'h0);
    exc_valid = 0; redirect_valid = 0; stall = 0;
    tick();
    chk("exc_ifid", ifid_pc, 32'h100);

    redirect_to(32'h42);
    chk("mis_fault", {31'b0, ifid_fault}, 32'h1);
    chk("mis_instr", ifid_instr, 32'h0);
    chk("mis_ifid", ifid_pc, 32'h42);

    redirect_to(32'hFFC);
    chk("last_word_fault", {31'b0, ifid_fault}, 32'h0);
    tick();
    chk("oob_fault", {31'b0, ifid_fault}, 32'h1);
    chk("oob_ifid", ifid_pc, 32'h1000);

    redirect_to(32'hFFFF_FFFC);
    chk("wrap_pc", imem_pc, 32'h0);
    chk("wrap_pc4", ifid_pc_plus4, 32'h0);

    rst = 1; redirect_valid = 1; redirect_pc = 32'h80;
    tick();
    chk("midrst_pc", imem_pc, RST_PC);
    chk("midrst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("midrst_instr", ifid_instr, 32'h0);
    chk("midrst_ifid", ifid_pc, 32'h0);
    chk("midrst_pc4", ifid_pc_plus4, 32'h0);
    rst = 0; redirect_valid = 0;
    tick();
    chk("after_rst_ifid", ifid_pc, RST_PC);

    // randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 49) == 0);
      exc_valid      = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = 32'($urandom_range(0, 1023)) << 2;
        1: redirect_pc = $urandom;
        2: redirect_pc = 32'($urandom_range(1000, 1100)) << 2;
        default: redirect_pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_0100: PC value loaded on exception entry.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1: hold the PC and IF/ID contents.
REQ-006 SHALL have port flush  input  1: invalidate the IF/ID register.
REQ-007 SHALL have port redirect_valid  input  1: branch/jump taken this cycle.
REQ-008 SHALL have port redirect_pc  input  `WORD_SIZE: branch/jump target.
REQ-009 SHALL have port exc_valid  input  1: exception entry request.
REQ-010 SHALL have port imem_pc  output  `WORD_SIZE: address to instruction memory, equal to the PC register.
REQ-011 SHALL have port imem_instr  input  `WORD_SIZE: combinational instruction-memory read data for imem_pc.
REQ-012 SHALL have port ifid_valid  output  1: the IF/ID entry holds a real instruction.
REQ-013 SHALL have port ifid_instr  output  `WORD_SIZE: latched instruction.
REQ-014 SHALL have port ifid_pc  output  `WORD_SIZE: PC of ifid_instr.
REQ-015 SHALL have port ifid_pc_plus4  output  `WORD_SIZE: ifid_pc + 4.
REQ-016 SHALL have port ifid_fault  output  1: the latched fetch was misaligned or out of range.

Function
REQ-017 SHALL drive imem_pc directly from the PC register, with no extra latency; the instruction is sampled in the same cycle.
REQ-018 SHALL compute the next PC with this priority: rst > exc_valid > redirect_valid > stall > sequential (PC+4).
REQ-019 SHALL load EXC_VECTOR into the PC when exc_valid=1, regardless of stall.
REQ-020 SHALL load redirect_pc into the PC when redirect_valid=1 and exc_valid=0, regardless of stall.
REQ-021 SHALL hold the PC when stall=1 and there is no exception or redirect.
REQ-022 SHALL otherwise set the PC to PC+4, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is permitted.
REQ-023 SHALL, for the IF/ID register, clear ifid_valid when flush, exc_valid or redirect_valid is 1 (wrong-path fetch discarded), with flush dominating stall.
REQ-024 SHALL, for the IF/ID register, hold all ifid_* outputs unchanged when stall=1 and no clearing event occurs.
REQ-025 SHALL, for the IF/ID register, otherwise latch imem_instr, PC, PC+4 and the fault bit, and set ifid_valid=1.
REQ-026 SHALL set the fault bit when PC[1:0]!=0 or PC[31:2] >= `INSTR_MEM_SIZE; a faulting fetch still latches, with ifid_instr forced to 0.
REQ-027 SHALL load a misaligned redirect_pc unmodified; the fault is flagged on that fetch.
REQ-028 SHALL treat ifid_instr, ifid_pc and ifid_pc_plus4 as don't-care when ifid_valid=0; they retain their last values unless cleared on reset.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, set PC=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus4=0 and ifid_fault=0, overriding every other input.
REQ-030 SHALL have the first valid IF/ID entry appear one cycle after rst deasserts, carrying PC=RESET_PC.
REQ-031 SHALL let a reset asserted mid-stall or during a redirect discard all pending state; no redirect is remembered.

Structure
REQ-032 SHALL take `WORD_SIZE and `INSTR_MEM_SIZE from the shared constants include; RESET_PC and EXC_VECTOR defaults also live there as named constants.
REQ-033 SHALL keep the PC register with its next-PC priority mux as one sub-module, pc_reg; the IF/ID register stays in fetch_stage.

Verification
REQ-034 SHALL cover reset then free run: rst for 2 cycles, release -> ifid_pc sequence 0, 4, 8 on consecutive cycles with ifid_valid=1 from the first cycle after release.
REQ-035 SHALL cover stall: stall=1 for 3 cycles at PC=8 -> imem_pc stays 8 and ifid_pc stays 4, valid; release -> ifid_pc=8 next cycle.
REQ-036 SHALL cover redirect: redirect_valid=1, redirect_pc=32'h40 at PC=12 -> next cycle imem_pc=32'h40 and ifid_valid=0; the following cycle ifid_pc=32'h40.
REQ-037 SHALL cover simultaneous events: exc_valid, redirect_valid (32'h80) and stall all =1 -> PC=EXC_VECTOR (32'h100) and ifid_valid=0.
REQ-038 SHALL cover faults: redirect_pc=32'h42 -> ifid_fault=1, ifid_instr=0; a PC at word index `INSTR_MEM_SIZE -> ifid_fault=1.
REQ-039 SHALL cover reset mid-operation: rst=1 together with redirect_valid=1 -> PC=RESET_PC and all ifid_* outputs =0.
